sm_bus_arbiter: RTL and testbench

SM_BUS_ARBITER -- requirements
Module: sm_bus_arbiter

---
 rtl/sm_bus_arbiter_if.sv | 32 +++
 rtl/sm_bus_arbiter.sv | 114 +++++++++++
 tb/tb_sm_bus_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sm_bus_arbiter_if.sv
// Bus bundle for the two-master arbiter: master request/response pairs plus the shared slave bus.
// The "slave" modport is the arbiter's view; the "master" modport is the environment's view.
interface sm_bus_arbiter_if;
  logic        m0Req;
  logic        m1Req;
  logic        m0We;
  logic        m1We;
  logic [31:0] m0Addr;
  logic [31:0] m1Addr;
  logic [31:0] m0WData;
  logic [31:0] m1WData;
  logic        m0Ack;
  logic        m1Ack;
  logic [31:0] m0RData;
  logic [31:0] m1RData;
  logic [31:0] sAddr;
  logic        sWe;
  logic [31:0] sWData;
  logic [31:0] sRData;
  logic        busy;
  logic        grantId;

  modport slave (
    input  m0Req, m1Req, m0We, m1We, m0Addr, m1Addr, m0WData, m1WData, sRData,
    output m0Ack, m1Ack, m0RData, m1RData, sAddr, sWe, sWData, busy, grantId
  );

  modport master (
    output m0Req, m1Req, m0We, m1We, m0Addr, m1Addr, m0WData, m1WData, sRData,
    input  m0Ack, m1Ack, m0RData, m1RData, sAddr, sWe, sWData, busy, grantId
  );
endinterface

// File: rtl/sm_bus_arbiter.sv
// Two-master arbiter for a shared single-cycle slave bus: IDLE -> ACCESS -> RESP, one transaction per 3 cycles.
// Round-robin or fixed priority with a starvation guard for master 1; all outputs come straight from registers.
module sm_bus_arbiter #(
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  sm_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  logic [3:0]  starveCnt;
  logic        lastGrant;
  logic        winner;
  logic        contested;
  logic        sWeR;
  logic [31:0] sAddrR;
  logic [31:0] sWDataR;
  logic        m0AckR;
  logic        m1AckR;
  logic [31:0] m0RDataR;
  logic [31:0] m1RDataR;
  logic        busyR;
  logic        grantR;

  assign contested = bus.m0Req & bus.m1Req;

  always_comb begin
    winner = bus.m1Req;
    if (contested) begin
      if (PRIO_MODE == 0) begin
        winner = ~lastGrant;
      end else begin
        winner = (starveCnt == LIMIT);
      end
    end
  end

  // The slave-bus registers double as the request latch: loaded in IDLE, cleared on leaving ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      starveCnt <= 4'd0;
      lastGrant <= 1'b1;
      sWeR      <= 1'b0;
      sAddrR    <= 32'd0;
      sWDataR   <= 32'd0;
      m0AckR    <= 1'b0;
      m1AckR    <= 1'b0;
      m0RDataR  <= 32'd0;
      m1RDataR  <= 32'd0;
      busyR     <= 1'b0;
      grantR    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0Req | bus.m1Req) begin
            state     <= ACCESS;
            busyR     <= 1'b1;
            grantR    <= winner;
            lastGrant <= winner;
            sWeR      <= winner ? bus.m1We    : bus.m0We;
            sAddrR    <= winner ? bus.m1Addr  : bus.m0Addr;
            sWDataR   <= winner ? bus.m1WData : bus.m0WData;
            if (winner) begin
              starveCnt <= 4'd0;
            end else if (contested && starveCnt != LIMIT) begin
              starveCnt <= starveCnt + 4'd1;
            end
          end
        end
        ACCESS: begin
          state   <= RESP;
          sWeR    <= 1'b0;
          sAddrR  <= 32'd0;
          sWDataR <= 32'd0;
          // Capture the slave read data into the winner's response register.
          if (grantR) begin
            m1AckR   <= 1'b1;
            m1RDataR <= bus.sRData;
          end else begin
            m0AckR   <= 1'b1;
            m0RDataR <= bus.sRData;
          end
        end
        RESP: begin
          state    <= IDLE;
          busyR    <= 1'b0;
          m0AckR   <= 1'b0;
          m1AckR   <= 1'b0;
          m0RDataR <= 32'd0;
          m1RDataR <= 32'd0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sWe     = sWeR;
  assign bus.sAddr   = sAddrR;
  assign bus.sWData  = sWDataR;
  assign bus.m0Ack   = m0AckR;
  assign bus.m1Ack   = m1AckR;
  assign bus.m0RData = m0RDataR;
  assign bus.m1RData = m1RDataR;
  assign bus.busy    = busyR;
  assign bus.grantId = grantR;
endmodule

// File: tb/tb_sm_bus_arbiter.sv
// Randomized bench for sm_bus_arbiter: one round-robin and one fixed-priority instance, each checked
// every cycle against a transaction-queue model of the arbitration rules.
module tb_sm_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   phase = 0;  // 0 directed, 1 random, 2 both continuous, 3 master-1 writes

  always #5 clk = ~clk;

  typedef struct {
    bit          isResp;
    int          gnt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Combinational slave: fixed pattern per address, with 0x10 holding 0xDEADBEEF.
  function automatic logic [31:0] memFunc(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : gDut
    localparam int LIMIT = (gi == 1) ? 2 : 4;

    sm_bus_arbiter_if bus ();

    sm_bus_arbiter #(.PRIO_MODE(gi), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.sRData = memFunc(bus.sAddr);

    exp_t        q[$];
    int          curGrant = 0;
    int          lastG = 1;
    int          starve = 0;
    bit          reqV[2];
    bit          weV[2];
    logic [31:0] addrV[2];
    logic [31:0] wdataV[2];
    int          dirIdx = 0;
    int          dirM[4]     = '{0, 1, 0, 1};
    bit          dirWe[4]    = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] dirAddr[4]  = '{32'h10, 32'h7F00, 32'h20, 32'h10};
    logic [31:0] dirWData[4] = '{32'h0, 32'hA5A5, 32'h1234_5678, 32'h0};
    int          contLog[$];
    int          contCyc[$];
    bit          contDone = 0;
    int          cyc = 0;
    string       p = $sformatf("d%0d_", gi);

    always @(negedge clk) begin : pModel
      exp_t     e;
      bit       idleCyc;
      bit [1:0] ackObs;
      int       g;
      int       w;
      bit       both;
      bit       start;
      int       expSeq[6];

      cyc++;
      idleCyc = 1'b0;
      ackObs  = {bus.m1Ack, bus.m0Ack};
      if (rst) begin
        q.delete();
        contLog.delete();
        contCyc.delete();
        curGrant = 0;
        lastG    = 1;
        starve   = 0;
        checkVal({p, "rst_sWe"},     32'(bus.sWe),     32'd0);
        checkVal({p, "rst_sAddr"},   bus.sAddr,        32'd0);
        checkVal({p, "rst_sWData"},  bus.sWData,       32'd0);
        checkVal({p, "rst_busy"},    32'(bus.busy),    32'd0);
        checkVal({p, "rst_grantId"}, 32'(bus.grantId), 32'd0);
        checkVal({p, "rst_m0Ack"},   32'(bus.m0Ack),   32'd0);
        checkVal({p, "rst_m1Ack"},   32'(bus.m1Ack),   32'd0);
        checkVal({p, "rst_m0RData"}, bus.m0RData,      32'd0);
        checkVal({p, "rst_m1RData"}, bus.m1RData,      32'd0);
      end else begin
        if (q.size() == 0) begin
          idleCyc = 1'b1;
          g = curGrant;
          checkVal({p, "idle_sWe"},   32'(bus.sWe),   32'd0);
          checkVal({p, "idle_sAddr"}, bus.sAddr,      32'd0);
          checkVal({p, "idle_busy"},  32'(bus.busy),  32'd0);
          checkVal({p, "idle_acks"},  32'(ackObs),    32'd0);
        end else begin
          e = q.pop_front();
          g = e.gnt;
          checkVal({p, "busy"}, 32'(bus.busy), 32'd1);
          if (!e.isResp) begin
            checkVal({p, "acc_sWe"},    32'(bus.sWe), 32'(e.we));
            checkVal({p, "acc_sAddr"},  bus.sAddr,    e.addr);
            checkVal({p, "acc_sWData"}, bus.sWData,   e.wdata);
            checkVal({p, "acc_acks"},   32'(ackObs),  32'd0);
          end else begin
            checkVal({p, "resp_sWe"},   32'(bus.sWe), 32'd0);
            checkVal({p, "resp_sAddr"}, bus.sAddr,    32'd0);
            checkVal({p, "resp_acks"},  32'(ackObs),  (g == 1) ? 32'd2 : 32'd1);
            checkVal({p, "resp_rdata"}, (g == 1) ? bus.m1RData : bus.m0RData, memFunc(e.addr));
            $display("txn dut=%0d cyc=%0d m=%0d we=%0d addr=%08h rdata=%08h",
                     gi, cyc, g, e.we, e.addr, (g == 1) ? bus.m1RData : bus.m0RData);
          end
        end
        checkVal({p, "grantId"}, 32'(bus.grantId), 32'(g));
        checkVal({p, "loser_rdata"}, (g == 1) ? bus.m0RData : bus.m1RData, 32'd0);
      end

      // Grant order observed on the DUT acks while both masters request continuously.
      if (phase == 2 && !rst && ackObs != 2'b00 && !contDone) begin
        contLog.push_back(int'(ackObs[1]));
        contCyc.push_back(cyc);
        if (contLog.size() == 6) begin
          if (gi == 0) expSeq = '{0, 1, 0, 1, 0, 1};
          else         expSeq = '{0, 0, 1, 0, 0, 1};
          for (int k = 0; k < 6; k++) begin
            checkVal({p, $sformatf("cont_grant%0d", k)}, 32'(contLog[k]), 32'(expSeq[k]));
            if (k > 0) checkVal({p, $sformatf("cont_gap%0d", k)}, 32'(contCyc[k] - contCyc[k-1]), 32'd3);
          end
          contDone = 1'b1;
        end
      end

      // Master behaviour: hold req until ack, then optionally re-request.
      for (int i = 0; i < 2; i++) begin
        start = 1'b0;
        if (ackObs[i]) begin
          reqV[i] = 1'b0;
          start = (phase == 1 && $urandom_range(0, 1) == 1) || phase == 2 || (phase == 3 && i == 1);
        end else if (!reqV[i]) begin
          start = (phase == 1 && $urandom_range(0, 3) == 0) || phase == 2 || (phase == 3 && i == 1);
        end
        if (start) begin
          reqV[i]   = 1'b1;
          weV[i]    = (phase == 3) ? 1'b1 : 1'($urandom_range(0, 1));
          addrV[i]  = ($urandom_range(0, 7) == 0) ? 32'h10 : 32'($urandom);
          wdataV[i] = 32'($urandom);
        end
      end
      if (phase == 0 && !reqV[0] && !reqV[1] && dirIdx < 4) begin
        w         = dirM[dirIdx];
        reqV[w]   = 1'b1;
        weV[w]    = dirWe[dirIdx];
        addrV[w]  = dirAddr[dirIdx];
        wdataV[w] = dirWData[dirIdx];
        dirIdx++;
      end

      // Fields only matter at a sampling edge; elsewhere they are scrambled.
      bus.m0Req = reqV[0];
      bus.m1Req = reqV[1];
      if (idleCyc) begin
        bus.m0We = weV[0]; bus.m0Addr = addrV[0]; bus.m0WData = wdataV[0];
        bus.m1We = weV[1]; bus.m1Addr = addrV[1]; bus.m1WData = wdataV[1];
      end else begin
        bus.m0We = 1'($urandom); bus.m0Addr = 32'($urandom); bus.m0WData = 32'($urandom);
        bus.m1We = 1'($urandom); bus.m1Addr = 32'($urandom); bus.m1WData = 32'($urandom);
      end

      if (idleCyc && (reqV[0] || reqV[1])) begin
        both = reqV[0] && reqV[1];
        if (!both)       w = reqV[1] ? 1 : 0;
        else if (gi == 0) w = 1 - lastG;
        else             w = (starve == LIMIT) ? 1 : 0;
        if (w == 1)    starve = 0;
        else if (both) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
        lastG    = w;
        curGrant = w;
        q.push_back('{1'b0, w, weV[w], addrV[w], wdataV[w]});
        q.push_back('{1'b1, w, weV[w], addrV[w], wdataV[w]});
      end
    end
  end

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (25) @(negedge clk);

    phase = 1;
    repeat (600) @(negedge clk);

    // Both masters continuously requesting from a fresh reset.
    phase = 2;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      found = gDut[0].contDone && gDut[1].contDone;
    end
    checkVal("cont_done", 32'(found), 32'd1);

    // Reset pulse during the ACCESS cycle of a write.
    phase = 3;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      found = (gDut[0].bus.sWe === 1'b1);
    end
    checkVal("abort_write_seen", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkVal("abort_sWe",   32'(gDut[0].bus.sWe),   32'd0);
    checkVal("abort_sAddr", gDut[0].bus.sAddr,      32'd0);
    checkVal("abort_busy",  32'(gDut[0].bus.busy),  32'd0);
    checkVal("abort_m0Ack", 32'(gDut[0].bus.m0Ack), 32'd0);
    checkVal("abort_m1Ack", 32'(gDut[0].bus.m1Ack), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
